// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multiplexed seven-segment driver: arrow lane (GAME) or decimal value (NUMBER)
//
// Ports:
//   clk, rst       : system clock, asynchronous active-high reset
//   metronome_clk  : asynchronous beat input, synchronised internally
//   mode           : 0 = GAME (scrolling arrow lane), 1 = NUMBER (decimal value)
//   next_arrow     : code shifted into the lane head on each GAME-mode beat
//   value          : binary value, captured on value_load
//   value_load     : single-cycle strobe that (re)starts the BCD conversion
//   seg            : active-low segment pattern, registered together with an
//   an             : active-low one-hot anode, an[NUM_DIGITS-1] = leftmost slot
//   cur_arrow      : lane tail, the arrow currently being judged
//   busy           : conversion in progress
module seg_display_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_BITS  = 14,
  parameter int CODE_BITS   = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  metronome_clk,
  input  logic                  mode,
  input  logic [CODE_BITS-1:0]  next_arrow,
  input  logic [VALUE_BITS-1:0] value,
  input  logic                  value_load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [CODE_BITS-1:0]  cur_arrow,
  output logic                  busy
);

  localparam int BCD_W  = 4 * NUM_DIGITS + 4;
  localparam int CNT_W  = $clog2(VALUE_BITS + 1);
  localparam int SLOT_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam logic [CODE_BITS-1:0] CODE_NONE = CODE_BITS'(20);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  function automatic logic [6:0] seg_decode(input logic [CODE_BITS-1:0] code);
    logic [7:0] c;
    c = 8'(code);
    case (c)
      8'd0:  seg_decode = 7'h40;
      8'd1:  seg_decode = 7'h79;
      8'd2:  seg_decode = 7'h24;
      8'd3:  seg_decode = 7'h30;
      8'd4:  seg_decode = 7'h19;
      8'd5:  seg_decode = 7'h12;
      8'd6:  seg_decode = 7'h02;
      8'd7:  seg_decode = 7'h78;
      8'd8:  seg_decode = 7'h00;
      8'd9:  seg_decode = 7'h10;
      8'd10: seg_decode = 7'h5C;  // arrow up
      8'd11: seg_decode = 7'h63;  // arrow down
      8'd12: seg_decode = 7'h4F;  // arrow left
      8'd13: seg_decode = 7'h71;  // arrow right
      8'd14: seg_decode = 7'h3C;
      8'd15: seg_decode = 7'h1E;
      8'd16: seg_decode = 7'h0E;
      8'd17: seg_decode = 7'h38;
      8'd18: seg_decode = 7'h27;
      8'd19: seg_decode = 7'h4B;
      default: seg_decode = 7'h7F;  // 20 = ARROW_NONE / blank, and anything above
    endcase
  endfunction

  // Beat detect: two sync flops, an edge flop, and a registered pulse so the
  // lane shifts three edges after the rise is first sampled.
  logic sync1_q, sync2_q, sync3_q, beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      sync1_q <= metronome_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      beat_q  <= sync2_q & ~sync3_q;
    end
  end

  // Arrow lane: lane_q[0] is the head, lane_q[NUM_DIGITS-1] the judged tail.
  logic [CODE_BITS-1:0] lane_q [NUM_DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) lane_q[i] <= CODE_NONE;
    end else if (beat_q && !mode) begin
      lane_q[0] <= next_arrow;
      for (int i = 1; i < NUM_DIGITS; i++) lane_q[i] <= lane_q[i-1];
    end
  end

  assign cur_arrow = lane_q[NUM_DIGITS-1];

  // Converter. The load strobe is registered first; a registered strobe in any
  // state restarts the conversion, so the most recent load always wins.
  state_e                  state_q, state_d;
  logic                    load_q;
  logic [VALUE_BITS-1:0]   vcap_q, shv_q;
  logic [BCD_W-1:0]        bcd_q, bcd_adj;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [4*NUM_DIGITS-1:0] dig_q;
  logic                    sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_q) begin
      state_d = S_SHIFT;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_SHIFT: if (bit_cnt_q == CNT_W'(1)) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // The extra top nibble only becomes nonzero when value >= 10^NUM_DIGITS.
  assign sat = |bcd_q[BCD_W-1 -: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q    <= 1'b0;
      vcap_q    <= '0;
      shv_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      dig_q     <= '0;
    end else begin
      load_q <= value_load;
      if (value_load) vcap_q <= value;
      if (load_q) begin
        bcd_q     <= '0;
        shv_q     <= vcap_q;
        bit_cnt_q <= CNT_W'(VALUE_BITS);
      end else if (state_q == S_SHIFT) begin
        bcd_q     <= {bcd_adj[BCD_W-2:0], shv_q[VALUE_BITS-1]};
        shv_q     <= shv_q << 1;
        bit_cnt_q <= bit_cnt_q - 1'b1;
      end else if (state_q == S_DONE) begin
        dig_q <= sat ? {NUM_DIGITS{4'd9}} : bcd_q[4*NUM_DIGITS-1:0];
      end
    end
  end

  // Scan: slot 0 is the leftmost digit; seg and an are registered from the
  // same slot index so they can never disagree.
  logic [REF_W-1:0]      ref_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [CODE_BITS-1:0]  code_d;
  logic [3:0]            dig_k;
  logic                  nz_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q  <= '0;
      slot_q <= '0;
      seg_q  <= 7'h7F;
      an_q   <= '1;
    end else begin
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
        ref_q  <= '0;
        slot_q <= (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  // nz_seen accumulates from the leftmost slot, so it marks leading zeros.
  always_comb begin
    code_d  = CODE_NONE;
    an_d    = '1;
    nz_seen = 1'b0;
    dig_k   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_k = dig_q[4*(NUM_DIGITS-1-k) +: 4];
      if (dig_k != 4'd0) nz_seen = 1'b1;
      if (slot_q == SLOT_W'(k)) begin
        an_d[NUM_DIGITS-1-k] = 1'b0;
        if (!mode)
          code_d = lane_q[NUM_DIGITS-1-k];
        else if (BLANK_LZ != 0 && !nz_seen && k != NUM_DIGITS - 1)
          code_d = CODE_NONE;
        else
          code_d = CODE_BITS'(dig_k);
      end
    end
    seg_d = seg_decode(code_d);
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - self-checking bench for seg_display_mux against a behavioural model
module tb_seg_display_mux;

  localparam int N  = 4;
  localparam int VB = 14;
  localparam int CB = 5;
  localparam int R  = 4;

  localparam logic [6:0] SEG_T [0:20] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h5C, 7'h63, 7'h4F, 7'h71, 7'h3C, 7'h1E, 7'h0E, 7'h38, 7'h27, 7'h4B,
    7'h7F};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          metronome_clk = 1'b0;
  logic          mode = 1'b0;
  logic [CB-1:0] next_arrow = '0;
  logic [VB-1:0] value = '0;
  logic          value_load = 1'b0;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic [CB-1:0] cur_arrow;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  seg_display_mux #(
    .NUM_DIGITS(N), .VALUE_BITS(VB), .CODE_BITS(CB), .REFRESH_DIV(R), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .metronome_clk(metronome_clk), .mode(mode),
    .next_arrow(next_arrow), .value(value), .value_load(value_load),
    .seg(seg), .an(an), .cur_arrow(cur_arrow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   cyc = 0;
  int   lane_m [N] = '{20, 20, 20, 20};
  int   dv = 0;
  int   ld_last = -100, ld_prev = -100, ld_val = 0;
  int   beat_at [$];
  bit   met_prev = 1'b0;
  int   exp_seg = 'h7F, exp_an = 'hF, exp_cur = 20, exp_busy = 0;
  bit   exp_valid = 1'b0;

  function automatic bit in_win(input int d);
    return (d >= 1) && (d <= VB + 1);
  endfunction

  function automatic int model_seg(input int s, input bit md);
    int code, p;
    if (!md) begin
      code = lane_m[N-1-s];
    end else begin
      p = 10 ** (N - 1 - s);
      if (s < N - 1 && dv < p) code = 20;
      else                     code = (dv / p) % 10;
    end
    return (code <= 20) ? int'(SEG_T[code]) : 'h7F;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      for (int i = 0; i < N; i++) lane_m[i] = 20;
      dv = 0; ld_last = -100; ld_prev = -100;
      beat_at.delete();
      met_prev = 1'b0;
      exp_seg = 'h7F; exp_an = 'hF; exp_cur = 20; exp_busy = 0;
      exp_valid = 1'b0;
    end else begin
      int s;
      cyc++;
      s = ((cyc - 1) / R) % N;
      exp_seg = model_seg(s, mode);
      exp_an  = 'hF & ~(1 << (N - 1 - s));
      if (cyc == ld_last + VB + 2) dv = (ld_val >= 10 ** N) ? 10 ** N - 1 : ld_val;
      if (metronome_clk && !met_prev) beat_at.push_back(cyc + 3);
      met_prev = metronome_clk;
      if (beat_at.size() > 0 && beat_at[0] == cyc) begin
        void'(beat_at.pop_front());
        if (!mode) begin
          for (int i = N - 1; i > 0; i--) lane_m[i] = lane_m[i-1];
          lane_m[0] = int'(next_arrow);
        end
      end
      if (value_load) begin
        ld_prev = ld_last; ld_last = cyc; ld_val = int'(value);
      end
      exp_busy  = (in_win(cyc - ld_last) || (cyc == ld_last && in_win(cyc - ld_prev))) ? 1 : 0;
      exp_cur   = lane_m[N-1];
      exp_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && exp_valid) begin
      check("seg", int'(seg), exp_seg);
      check("an", int'(an), exp_an);
      check("cur_arrow", int'(cur_arrow), exp_cur);
      check("busy", int'(busy), exp_busy);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input int arrow);
    next_arrow = CB'(arrow);
    metronome_clk = 1'b1; tick(4);
    metronome_clk = 1'b0; tick(4);
  endtask

  task automatic load(input int v);
    value = VB'(v); value_load = 1'b1; tick(1); value_load = 1'b0;
  endtask

  task automatic wait_slot(input logic [N-1:0] a, output logic [6:0] s);
    int i = 0;
    while (an !== a && i < 64) begin @(negedge clk); i++; end
    if (an !== a) check("slot_wait", int'(an), int'(a));
    s = seg;
  endtask

  initial begin
    logic [6:0] sg;
    int cnt, ph;

    tick(3);
    check("rst_seg", int'(seg), 'h7F);
    check("rst_an", int'(an), 'hF);
    check("rst_cur", int'(cur_arrow), 20);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick(1);
    check("first_an", int'(an), 'b0111);
    check("first_seg", int'(seg), 'h7F);

    beat(10); check("beat1_cur", int'(cur_arrow), 20);
    beat(11); check("beat2_cur", int'(cur_arrow), 20);
    beat(12); check("beat3_cur", int'(cur_arrow), 20);
    beat(13); check("beat4_cur", int'(cur_arrow), 10);
    wait_slot(4'b0111, sg); check("lane_slot0", int'(sg), 'h5C);

    mode = 1'b1;
    load(1234);
    cnt = 0;
    repeat (30) begin if (busy) cnt++; @(negedge clk); end
    check("busy_cycles", cnt, 15);
    wait_slot(4'b0111, sg); check("n1234_s0", int'(sg), 'h79);
    wait_slot(4'b1011, sg); check("n1234_s1", int'(sg), 'h24);
    wait_slot(4'b1101, sg); check("n1234_s2", int'(sg), 'h30);
    wait_slot(4'b1110, sg); check("n1234_s3", int'(sg), 'h19);

    load(16383); tick(20);
    wait_slot(4'b0111, sg); check("sat_s0", int'(sg), 'h10);
    wait_slot(4'b1110, sg); check("sat_s3", int'(sg), 'h10);

    load(7); tick(20);
    wait_slot(4'b0111, sg); check("n7_s0", int'(sg), 'h7F);
    wait_slot(4'b1011, sg); check("n7_s1", int'(sg), 'h7F);
    wait_slot(4'b1101, sg); check("n7_s2", int'(sg), 'h7F);
    wait_slot(4'b1110, sg); check("n7_s3", int'(sg), 'h78);

    load(0); tick(20);
    wait_slot(4'b1101, sg); check("n0_s2", int'(sg), 'h7F);
    wait_slot(4'b1110, sg); check("n0_s3", int'(sg), 'h40);

    load(500); tick(4); load(42);
    cnt = 0;
    repeat (40) begin if (seg == 7'h12) cnt++; @(negedge clk); end
    check("restart_no_500", cnt, 0);
    wait_slot(4'b1011, sg); check("n42_s1", int'(sg), 'h7F);
    wait_slot(4'b1101, sg); check("n42_s2", int'(sg), 'h19);
    wait_slot(4'b1110, sg); check("n42_s3", int'(sg), 'h24);

    beat(14); beat(15); beat(16);
    check("hold_cur", int'(cur_arrow), 10);
    mode = 1'b0; tick(2);
    wait_slot(4'b0111, sg); check("hold_slot0", int'(sg), 'h5C);

    ph = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ph >= 3 && $urandom_range(0, 3) == 0) begin
        metronome_clk = ~metronome_clk; ph = 0;
      end else begin
        ph++;
      end
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      next_arrow = CB'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0:       value = VB'($urandom_range(0, 16383));
        1:       value = VB'($urandom_range(0, 99));
        default: value = VB'($urandom_range(0, 9));
      endcase
      value_load = ($urandom_range(0, 24) == 0);
      tick(1);
    end
    value_load = 1'b0; metronome_clk = 1'b0; mode = 1'b0;
    tick(10);

    load(1234); tick(5);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_an", int'(an), 'hF);
    check("async_seg", int'(seg), 'h7F);
    check("async_cur", int'(cur_arrow), 20);
    @(negedge clk); rst = 1'b0;
    tick(1);
    check("rerst_an", int'(an), 'b0111);
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
